// File: rtl/program_counter_pkg.sv
// Shared datapath constants for the processor core.
// WORD_SIZE is the architectural word width used by the fetch path and PC.
package program_counter_pkg;

  localparam int WORD_SIZE = 32;

endpackage

// File: rtl/program_counter.sv
// Architectural program-counter register: loads PCNext on every rising edge.
// Asynchronous active-low reset forces PC to RESET_VECTOR.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH        = WORD_SIZE,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCNext,
  output logic [WIDTH-1:0] PC
);

  logic [WIDTH-1:0] r_pc;

  // No enable or stall: every edge loads, and reset overrides any pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= PCNext;
    end
  end

  assign PC = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed table, reset corner cases
// and randomized traffic against a simple "last loaded value" reference model.
module tb_program_counter;

  localparam int          W     = 32;
  localparam logic [31:0] RST_V = 32'h0;

  typedef struct {
    logic [31:0] pcNext;
    logic [31:0] expPc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] PCNext;
  logic [31:0] PC;

  int checks;
  int failures;

  program_counter #(.WIDTH(W), .RESET_VECTOR(RST_V)) dut (
    .clk    (clk),
    .rst    (rst),
    .PCNext (PCNext),
    .PC     (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: PC=%h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive between edges, then sample 1 time unit after the loading edge.
  task automatic applyStimulus(input logic [31:0] nextVal);
    @(negedge clk);
    PCNext = nextVal;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] modelPc;
  logic [31:0] rndNext;
  logic        rndRst;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    PCNext   = 32'h0;
    #1;
    checkOutput("reset_initial", PC, RST_V);

    // Reset held: edges do not load, whatever PCNext is.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0);
      checkOutput("reset_hold_zero", PC, RST_V);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'hFFFFFFFF);
      checkOutput("reset_dominates_load", PC, RST_V);
    end

    // Release between edges: PC unchanged until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release_no_change", PC, RST_V);
    @(posedge clk);
    #1;
    checkOutput("first_load_after_release", PC, 32'hFFFFFFFF);

    vecs.push_back('{32'h00000004, 32'h00000004});
    vecs.push_back('{32'h00000008, 32'h00000008});
    vecs.push_back('{32'h12345678, 32'h12345678});
    vecs.push_back('{32'hAAAAAAAA, 32'hAAAAAAAA});
    vecs.push_back('{32'h55555555, 32'h55555555});
    vecs.push_back('{32'hAAAAAAAA, 32'hAAAAAAAA});
    vecs.push_back('{32'h55555555, 32'h55555555});
    vecs.push_back('{32'h00000000, 32'h00000000});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{32'h80000001, 32'h80000001});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pcNext);
      checkOutput($sformatf("table_vec%0d", i), PC, vecs[i].expPc);
    end

    // Mid-cycle reset assertion: immediate effect, pending load discarded.
    applyStimulus(32'hDEADBEEF);
    checkOutput("load_deadbeef", PC, 32'hDEADBEEF);
    #2;
    PCNext = 32'hCAFEF00D;
    rst    = 1'b0;
    #1;
    checkOutput("async_reset_immediate", PC, RST_V);
    @(posedge clk);
    #1;
    checkOutput("async_reset_discards_load", PC, RST_V);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rerelease_no_change", PC, RST_V);
    @(posedge clk);
    #1;
    checkOutput("rerelease_first_load", PC, 32'hCAFEF00D);

    // Randomized traffic: model PC is the last value loaded while rst was high.
    modelPc = 32'hCAFEF00D;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rndRst  = ($urandom_range(0, 9) != 0);
      rndNext = $urandom();
      rst     = rndRst;
      PCNext  = rndNext;
      if (!rndRst) modelPc = RST_V;
      #1;
      checkOutput("rand_between_edges", PC, modelPc);
      @(posedge clk);
      if (rndRst) modelPc = rndNext;
      #1;
      checkOutput("rand_after_edge", PC, modelPc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
